// File: rtl/regfile_wb.sv
// Register file with pending-write scoreboard. Two async read ports, one sync write port, decode stall.
// Optional same-cycle writeback bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              stall,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;

    logic byp_rs, byp_rt, byp_iss;
    logic haz_rs, haz_rt, haz_iss;
    logic wr_ok, clr, set, cnt_inc, cnt_dec;

`ifdef REGFILE_BYPASS_EN
    assign byp_rs  = wr_en && (wr_addr == rs_addr)  && (rs_addr  != '0);
    assign byp_rt  = wr_en && (wr_addr == rt_addr)  && (rt_addr  != '0);
    assign byp_iss = wr_en && (wr_addr == iss_addr) && (iss_addr != '0);
`else
    assign byp_rs  = 1'b0;
    assign byp_rt  = 1'b0;
    assign byp_iss = 1'b0;
`endif

    assign haz_rs  = (rs_addr  != '0) && pend_q[rs_addr]  && !byp_rs;
    assign haz_rt  = (rt_addr  != '0) && pend_q[rt_addr]  && !byp_rt;
    assign haz_iss = (iss_addr != '0) && pend_q[iss_addr] && !byp_iss;

    assign stall    = haz_rs || haz_rt || (iss_en && haz_iss);
    assign pend_cnt = pend_cnt_q;

    assign rs_data = (rs_addr == '0) ? '0 : (byp_rs ? wr_data : regs_q[rs_addr]);
    assign rt_data = (rt_addr == '0) ? '0 : (byp_rt ? wr_data : regs_q[rt_addr]);

    always_comb begin
        regs_d     = regs_q;
        pend_d     = pend_q;
        pend_cnt_d = pend_cnt_q;
        wr_ok      = wr_en && (wr_addr != '0);
        clr        = wr_ok && pend_q[wr_addr];
        set        = iss_en && !stall && (iss_addr != '0);
        // A set on the index being cleared keeps the bit, so it must not decrement
        cnt_inc    = set && !pend_q[iss_addr];
        cnt_dec    = clr && !(set && (iss_addr == wr_addr));

        if (wr_ok) regs_d[wr_addr] = wr_data;
        if (clr)   pend_d[wr_addr] = 1'b0;
        if (set)   pend_d[iss_addr] = 1'b1;

        if (cnt_inc && !cnt_dec)      pend_cnt_d = pend_cnt_q + CNT_ONE;
        else if (cnt_dec && !cnt_inc) pend_cnt_d = pend_cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed vector table plus randomized run against a
// behavioural model of registers and reservation set. Honours REGFILE_BYPASS_EN like the RTL.
module tb_regfile_wb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr, wr_addr, iss_addr;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        wr_en, iss_en, stall;
    logic [5:0]  pend_cnt;

    regfile_wb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .stall(stall), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: register contents and set of reserved indices
    bit [31:0] m_r [32];
    bit        m_p [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_byp(input int a);
        return BYP && wr_en && (int'(wr_addr) == a) && (a != 0);
    endfunction

    function automatic bit m_haz(input int a);
        return (a != 0) && m_p[a] && !m_byp(a);
    endfunction

    function automatic bit m_stall();
        return m_haz(int'(rs_addr)) || m_haz(int'(rt_addr)) || (iss_en && m_haz(int'(iss_addr)));
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (m_byp(a)) return wr_data;
        return m_r[a];
    endfunction

    function automatic int m_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_p[i]);
        return n;
    endfunction

    task automatic apply(input bit rst, input int rs, input int rt, input bit wen, input int wa,
                         input logic [31:0] wd, input bit ien, input int ia);
        reset    = rst;
        rs_addr  = 5'(rs);
        rt_addr  = 5'(rt);
        wr_en    = wen;
        wr_addr  = 5'(wa);
        wr_data  = wd;
        iss_en   = ien;
        iss_addr = 5'(ia);
        #1;
    endtask

    // Advance one clock edge, updating the model from the inputs applied this cycle
    task automatic commit();
        bit st;
        bit do_clr, do_set;
        st = m_stall();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin m_r[i] = '0; m_p[i] = 1'b0; end
        end else begin
            do_clr = wr_en && (wr_addr != 0) && m_p[wr_addr];
            do_set = iss_en && !st && (iss_addr != 0);
            if (wr_en && wr_addr != 0) m_r[wr_addr] = wr_data;
            if (do_clr) m_p[wr_addr] = 1'b0;
            if (do_set) m_p[iss_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          rst;
        int          rs, rt;
        bit          wen;
        int          wa;
        logic [31:0] wd;
        bit          ien;
        int          ia;
        logic [31:0] e_rs, e_rt;
        bit          e_stall;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mk(bit rst, int rs, int rt, bit wen, int wa, logic [31:0] wd,
                                bit ien, int ia, logic [31:0] ers, logic [31:0] ert,
                                bit est, int ecnt);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt; v.wen = wen; v.wa = wa; v.wd = wd;
        v.ien = ien; v.ia = ia; v.e_rs = ers; v.e_rt = ert; v.e_stall = est; v.e_cnt = ecnt;
        return v;
    endfunction

    vec_t vecs [19];

    initial begin
        //            rst rs rt wen wa wd            ien ia  exp_rs                  exp_rt                  stall          cnt
        vecs[0]  = mk(0,  5, 31, 0, 0, 32'h0,        0,  0,  32'h0,                  32'h0,                  0,             0);
        vecs[1]  = mk(0,  0, 0,  1, 0, 32'hDEADBEEF, 0,  0,  32'h0,                  32'h0,                  0,             0);
        vecs[2]  = mk(0,  0, 7,  1, 7, 32'hDEADBEEF, 0,  0,  32'h0,                  BYP ? 32'hDEADBEEF : 0, 0,             0);
        vecs[3]  = mk(0,  7, 0,  0, 0, 32'h0,        0,  0,  32'hDEADBEEF,           32'h0,                  0,             0);
        vecs[4]  = mk(0,  0, 0,  0, 0, 32'h0,        1,  9,  32'h0,                  32'h0,                  0,             0);
        vecs[5]  = mk(0,  9, 0,  0, 0, 32'h0,        0,  0,  32'h0,                  32'h0,                  1,             1);
        vecs[6]  = mk(0,  9, 0,  1, 9, 32'h1234,     0,  0,  BYP ? 32'h1234 : 32'h0, 32'h0,                  !BYP,          1);
        vecs[7]  = mk(0,  9, 0,  0, 0, 32'h0,        0,  0,  32'h1234,               32'h0,                  0,             0);
        vecs[8]  = mk(0,  0, 0,  0, 0, 32'h0,        1,  4,  32'h0,                  32'h0,                  0,             0);
        vecs[9]  = mk(0,  0, 0,  0, 0, 32'h0,        1,  4,  32'h0,                  32'h0,                  1,             1);
        vecs[10] = mk(0,  0, 0,  0, 0, 32'h0,        0,  0,  32'h0,                  32'h0,                  0,             1);
        vecs[11] = mk(0,  0, 0,  1, 4, 32'hA,        1,  4,  32'h0,                  32'h0,                  !BYP,          1);
        vecs[12] = mk(0,  4, 0,  0, 0, 32'h0,        0,  0,  32'hA,                  32'h0,                  BYP,           BYP ? 1 : 0);
        vecs[13] = mk(0,  0, 0,  1, 4, 32'hA,        0,  0,  32'h0,                  32'h0,                  0,             BYP ? 1 : 0);
        vecs[14] = mk(0,  0, 0,  0, 0, 32'h0,        1,  2,  32'h0,                  32'h0,                  0,             0);
        vecs[15] = mk(0,  0, 0,  0, 0, 32'h0,        1,  3,  32'h0,                  32'h0,                  0,             1);
        vecs[16] = mk(0,  0, 0,  0, 0, 32'h0,        1,  4,  32'h0,                  32'h0,                  0,             2);
        vecs[17] = mk(1,  2, 3,  1, 5, 32'h55,       0,  0,  32'h0,                  32'h0,                  1,             3);
        vecs[18] = mk(0,  7, 5,  0, 0, 32'h0,        0,  0,  32'h0,                  32'h0,                  0,             0);

        apply(1, 0, 0, 0, 0, 32'h0, 0, 0);
        commit();

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].rst, vecs[i].rs, vecs[i].rt, vecs[i].wen, vecs[i].wa, vecs[i].wd,
                  vecs[i].ien, vecs[i].ia);
            check($sformatf("vec%0d rs_data", i),  rs_data,         vecs[i].e_rs);
            check($sformatf("vec%0d rt_data", i),  rt_data,         vecs[i].e_rt);
            check($sformatf("vec%0d stall", i),    32'(stall),      32'(vecs[i].e_stall));
            check($sformatf("vec%0d pend_cnt", i), 32'(pend_cnt),   32'(vecs[i].e_cnt));
            commit();
        end

        for (int i = 0; i < 800; i++) begin
            bit narrow;
            narrow = ($urandom_range(0, 3) != 0);
            apply($urandom_range(0, 79) == 0,
                  narrow ? $urandom_range(0, 7) : $urandom_range(0, 31),
                  narrow ? $urandom_range(0, 7) : $urandom_range(0, 31),
                  $urandom_range(0, 1) == 1,
                  narrow ? $urandom_range(0, 7) : $urandom_range(0, 31),
                  $urandom,
                  $urandom_range(0, 9) < 4,
                  narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
            check("rnd rs_data",  rs_data,       m_read(int'(rs_addr)));
            check("rnd rt_data",  rt_data,       m_read(int'(rt_addr)));
            check("rnd stall",    32'(stall),    32'(m_stall()));
            check("rnd pend_cnt", 32'(pend_cnt), 32'(m_cnt()));
            commit();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
